// File: rtl/instr_fetch_decode.sv
// Fetch-and-decode stage feeding the register file.
// Keeps the program counter, fetches one 32-bit MIPS instruction per req/ack
// handshake and registers its decoded fields. `pc` changes once per
// instruction (on DECODE entry) so downstream logic can qualify one write
// per instruction.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   stall               hold the decoded instruction (DECODE only)
//   branchTaken/Target  redirect request; target bits [1:0] forced to 0
//   imemReq/Addr        fetch request and address (Moore, FETCH state)
//   imemAck/Data        fetch completion and instruction word
//   pc                  address of the instruction currently presented
//   instrValid          decoded outputs valid (DECODE state)
//   regWrite            register write enable, gated by instrValid
//   address1/2/3        destination, rs, rt register addresses
//   immediate           extended immediate
//   opcode, funct       raw instruction fields
//   illegal             unsupported opcode
module instr_fetch_decode #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] pc,
  output logic        instrValid,
  output logic        regWrite,
  output logic [4:0]  address1,
  output logic [4:0]  address2,
  output logic [4:0]  address3,
  output logic [31:0] immediate,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        illegal
);

  typedef enum logic [1:0] {StIdle, StFetch, StDecode} state_e;

  localparam logic [5:0] OpJ = 6'h02;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [4:0]  a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic        we_q, we_d;
  logic [31:0] imm_q, imm_d;
  logic        ill_q, ill_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  // Decode of the incoming word, registered on the DECODE entry edge.
  logic [4:0]  dec_a1, dec_a2, dec_a3;
  logic        dec_we, dec_ill;
  logic [31:0] dec_imm;
  logic [5:0]  d_op;
  logic [4:0]  d_rs, d_rt, d_rd;
  logic [15:0] d_imm;

  assign d_op  = imemData[31:26];
  assign d_rs  = imemData[25:21];
  assign d_rt  = imemData[20:16];
  assign d_rd  = imemData[15:11];
  assign d_imm = imemData[15:0];

  always_comb begin
    dec_a1  = 5'd0;
    dec_a2  = 5'd0;
    dec_a3  = 5'd0;
    dec_we  = 1'b0;
    dec_imm = 32'd0;
    dec_ill = 1'b0;
    unique case (d_op)
      6'h00: begin
        dec_a1 = d_rd;
        dec_a2 = d_rs;
        dec_a3 = d_rt;
        dec_we = (imemData[5:0] != 6'h08) && (d_rd != 5'd0);
      end
      6'h08, 6'h09, 6'h0A, 6'h23: begin
        dec_a1  = d_rt;
        dec_a2  = d_rs;
        dec_we  = (d_rt != 5'd0);
        dec_imm = {{16{d_imm[15]}}, d_imm};
      end
      6'h0C, 6'h0D: begin
        dec_a1  = d_rt;
        dec_a2  = d_rs;
        dec_we  = (d_rt != 5'd0);
        dec_imm = {16'h0000, d_imm};
      end
      6'h0F: begin
        dec_a1  = d_rt;
        dec_we  = (d_rt != 5'd0);
        dec_imm = {d_imm, 16'h0000};
      end
      6'h2B, 6'h04, 6'h05: begin
        dec_a2  = d_rs;
        dec_a3  = d_rt;
        dec_imm = {{16{d_imm[15]}}, d_imm};
      end
      OpJ: ;
      default: dec_ill = 1'b1;
    endcase
  end

  // Next fetch address when leaving DECODE, in priority order.
  logic [31:0] pc_plus4, next_addr;
  logic        leave_decode;

  assign pc_plus4     = pc_q + 32'd4;
  assign leave_decode = (state_q == StDecode) && !stall;

  always_comb begin
    if (branchTaken)                 next_addr = {branchTarget[31:2], 2'b00};
    else if (pend_q)                 next_addr = pend_tgt_q;
    else if (instr_q[31:26] == OpJ)  next_addr = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    else                             next_addr = pc_plus4;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    a1_d       = a1_q;
    a2_d       = a2_q;
    a3_d       = a3_q;
    we_d       = we_q;
    imm_d      = imm_q;
    ill_d      = ill_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imemAck) begin
          state_d = StDecode;
          pc_d    = addr_q;
          instr_d = imemData;
          a1_d    = dec_a1;
          a2_d    = dec_a2;
          a3_d    = dec_a3;
          we_d    = dec_we;
          imm_d   = dec_imm;
          ill_d   = dec_ill;
        end
      end
      StDecode: begin
        if (!stall) begin
          state_d = StFetch;
          addr_d  = next_addr;
        end
      end
      default: state_d = StIdle;
    endcase
    // A branch seen outside the consuming cycle is remembered; latest wins.
    if (leave_decode) begin
      pend_d = 1'b0;
    end else if (branchTaken) begin
      pend_d     = 1'b1;
      pend_tgt_d = {branchTarget[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= PC_RESET;
      addr_q     <= PC_RESET;
      instr_q    <= 32'd0;
      a1_q       <= 5'd0;
      a2_q       <= 5'd0;
      a3_q       <= 5'd0;
      we_q       <= 1'b0;
      imm_q      <= 32'd0;
      ill_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      a3_q       <= a3_d;
      we_q       <= we_d;
      imm_q      <= imm_d;
      ill_q      <= ill_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign imemReq    = (state_q == StFetch);
  assign imemAddr   = addr_q;
  assign pc         = pc_q;
  assign instrValid = (state_q == StDecode);
  assign regWrite   = we_q & instrValid;
  assign address1   = a1_q;
  assign address2   = a2_q;
  assign address3   = a3_q;
  assign immediate  = imm_q;
  assign opcode     = instr_q[31:26];
  assign funct      = instr_q[5:0];
  assign illegal    = ill_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        reset, stall, branchTaken;
  logic [31:0] branchTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] pc;
  logic        instrValid, regWrite, illegal;
  logic [4:0]  address1, address2, address3;
  logic [31:0] immediate;
  logic [5:0]  opcode, funct;

  instr_fetch_decode #(.PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemData(imemData), .pc(pc), .instrValid(instrValid),
    .regWrite(regWrite), .address1(address1), .address2(address2),
    .address3(address3), .immediate(immediate), .opcode(opcode), .funct(funct),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  a1, a2, a3;
    logic        we;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  a1, a2, a3;
    logic        we;
    logic [31:0] imm;
    logic        ill;
    logic [5:0]  op, fn;
  } exp_t;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  logic [31:0] exp_addr;
  vec_t vecs[12];
  vec_t v_j;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Wait (bounded) for a fetch request; returns number of cycles waited.
  task automatic wait_req(output int cnt);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (imemReq) break;
    end
    chk("req_seen", {31'd0, imemReq}, 32'd1);
    chk("fetch_addr", imemAddr, exp_addr);
    chk("fetch_valid_low", {31'd0, instrValid}, 32'd0);
    chk("fetch_we_low", {31'd0, regWrite}, 32'd0);
  endtask

  // Ack in the current FETCH cycle; scoreboard checks the DECODE outputs.
  task automatic do_ack(input vec_t v);
    exp_t e, g;
    logic [31:0] w;
    w = v.instr;
    imemAck = 1'b1;
    imemData = w;
    e.pc = exp_addr; e.a1 = v.a1; e.a2 = v.a2; e.a3 = v.a3; e.we = v.we;
    e.imm = v.imm; e.ill = v.ill; e.op = w[31:26]; e.fn = w[5:0];
    sb.push_back(e);
    @(negedge clk);
    imemAck = 1'b0;
    imemData = $urandom;
    chk("instrValid", {31'd0, instrValid}, 32'd1);
    chk("decode_req_low", {31'd0, imemReq}, 32'd0);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      g = sb.pop_front();
      chk("pc", pc, g.pc);
      chk("address1", {27'd0, address1}, {27'd0, g.a1});
      chk("address2", {27'd0, address2}, {27'd0, g.a2});
      chk("address3", {27'd0, address3}, {27'd0, g.a3});
      chk("regWrite", {31'd0, regWrite}, {31'd0, g.we});
      chk("immediate", immediate, g.imm);
      chk("illegal", {31'd0, illegal}, {31'd0, g.ill});
      chk("opcode", {26'd0, opcode}, {26'd0, g.op});
      chk("funct", {26'd0, funct}, {26'd0, g.fn});
    end
    exp_addr = exp_addr + 32'd4;
  endtask

  task automatic fetch(input vec_t v, input bit chk_tput);
    int cnt;
    wait_req(cnt);
    if (chk_tput) chk("throughput_wait", cnt, 32'd1);
    do_ack(v);
  endtask

  initial begin
    int cnt;
    //           instr          a1     a2     a3     we    imm            ill
    vecs[0]  = '{32'h012A4020, 5'd8,  5'd9,  5'd10, 1'b1, 32'h0,         1'b0}; // add
    vecs[1]  = '{32'h2408FFFF, 5'd8,  5'd0,  5'd0,  1'b1, 32'hFFFFFFFF,  1'b0}; // addiu
    vecs[2]  = '{32'h3508FFFF, 5'd8,  5'd8,  5'd0,  1'b1, 32'h0000FFFF,  1'b0}; // ori
    vecs[3]  = '{32'h03E00008, 5'd0,  5'd31, 5'd0,  1'b0, 32'h0,         1'b0}; // jr ra
    vecs[4]  = '{32'h3C091234, 5'd9,  5'd0,  5'd0,  1'b1, 32'h12340000,  1'b0}; // lui
    vecs[5]  = '{32'hAFA8FFFC, 5'd0,  5'd29, 5'd8,  1'b0, 32'hFFFFFFFC,  1'b0}; // sw
    vecs[6]  = '{32'h8D000008, 5'd0,  5'd8,  5'd0,  1'b0, 32'h00000008,  1'b0}; // lw rt=0
    vecs[7]  = '{32'h312A8000, 5'd10, 5'd9,  5'd0,  1'b1, 32'h00008000,  1'b0}; // andi
    vecs[8]  = '{32'h292B8000, 5'd11, 5'd9,  5'd0,  1'b1, 32'hFFFF8000,  1'b0}; // slti
    vecs[9]  = '{32'h11090010, 5'd0,  5'd8,  5'd9,  1'b0, 32'h00000010,  1'b0}; // beq
    vecs[10] = '{32'hFC000000, 5'd0,  5'd0,  5'd0,  1'b0, 32'h0,         1'b1}; // illegal
    vecs[11] = '{32'h012A0020, 5'd0,  5'd9,  5'd10, 1'b0, 32'h0,         1'b0}; // add rd=0
    v_j      = '{32'h08000040, 5'd0,  5'd0,  5'd0,  1'b0, 32'h0,         1'b0}; // j 0x100

    reset = 1'b1; stall = 1'b0; branchTaken = 1'b0; branchTarget = 32'd0;
    imemAck = 1'b0; imemData = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imemAddr, 32'h0);
    chk("rst_req", {31'd0, imemReq}, 32'd0);
    chk("rst_valid", {31'd0, instrValid}, 32'd0);
    chk("rst_we", {31'd0, regWrite}, 32'd0);
    chk("rst_imm", immediate, 32'd0);
    reset = 1'b0;
    #1 chk("idle_req", {31'd0, imemReq}, 32'd0);
    exp_addr = 32'h0;

    for (int i = 0; i < 12; i++) fetch(vecs[i], 1'b1);

    // Stall for 3 cycles at 0x30: outputs frozen, no request.
    fetch(vecs[1], 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req", {31'd0, imemReq}, 32'd0);
      chk("stall_valid", {31'd0, instrValid}, 32'd1);
      chk("stall_pc", pc, 32'h30);
      chk("stall_addr", imemAddr, 32'h30);
      chk("stall_imm", immediate, 32'hFFFFFFFF);
      chk("stall_we", {31'd0, regWrite}, 32'd1);
    end
    stall = 1'b0;
    fetch(vecs[0], 1'b1); // 0x34

    // Pending branch raised in FETCH, overwritten while stalled in DECODE.
    wait_req(cnt);
    branchTaken = 1'b1; branchTarget = 32'h80;
    @(negedge clk);
    branchTaken = 1'b0;
    chk("wait_req_held", {31'd0, imemReq}, 32'd1);
    chk("wait_addr_held", imemAddr, 32'h38);
    do_ack(vecs[0]);
    stall = 1'b1; branchTaken = 1'b1; branchTarget = 32'h90;
    @(negedge clk);
    stall = 1'b0; branchTaken = 1'b0;
    exp_addr = 32'h90;
    fetch(vecs[0], 1'b0);
    fetch(vecs[0], 1'b0); // 0x94, pending consumed

    // Jump at 0x98 -> 0x100; jump at 0x100 overridden by same-cycle branch.
    fetch(v_j, 1'b0);
    exp_addr = 32'h100;
    fetch(v_j, 1'b0);
    branchTaken = 1'b1; branchTarget = 32'h203;
    @(negedge clk);
    branchTaken = 1'b0;
    exp_addr = 32'h200;

    // Illegal continues at pc+4, then reset while the request waits.
    fetch(vecs[10], 1'b0);
    wait_req(cnt);
    reset = 1'b1;
    #1;
    chk("async_req_drop", {31'd0, imemReq}, 32'd0);
    chk("async_pc", pc, 32'h0);
    chk("async_addr", imemAddr, 32'h0);
    chk("async_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    imemAck = 1'b1; imemData = 32'h2408FFFF;
    @(negedge clk);
    imemAck = 1'b0;
    chk("late_ack_valid", {31'd0, instrValid}, 32'd0);
    chk("late_ack_req", {31'd0, imemReq}, 32'd1);
    chk("late_ack_pc", pc, 32'h0);
    chk("late_ack_addr", imemAddr, 32'h0);
    exp_addr = 32'h0;
    do_ack(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Fetch-and-decode stage sitting directly upstream of the register file. It keeps the program counter and fetches one 32-bit MIPS instruction at a time from instruction memory over a req/ack handshake. It decodes the instruction into destination/source register addresses, a write enable and an extended immediate. It presents a new `pc` value exactly once per instruction; the register file uses that change to qualify a single write per instruction.

## Interface
- `PC_RESET`, 32'h0000_0000, address fetched first after reset
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high
- `stall`  in  1  downstream not ready; hold the decoded instruction
- `branchTaken`  in  1  redirect request from execute
- `branchTarget`  in  32  redirect address; bits [1:0] forced to 0
- `imemReq`  out  1  fetch request
- `imemAddr`  out  32  fetch address
- `imemAck`  in  1  fetch complete; `imemData` valid this cycle
- `imemData`  in  32  fetched instruction
- `pc`  out  32  address of the instruction currently presented
- `instrValid`  out  1  decoded outputs valid
- `regWrite`  out  1  instruction writes a register (0 whenever `instrValid`=0)
- `address1`  out  5  destination register
- `address2`  out  5  source rs
- `address3`  out  5  source rt
- `immediate`  out  32  extended immediate
- `opcode`  out  6  instr[31:26]
- `funct`  out  6  instr[5:0]
- `illegal`  out  1  unsupported opcode

## Operation
- FSM states: IDLE, FETCH, DECODE.
  - IDLE→FETCH unconditionally.
  - FETCH: `imemReq`=1 (Moore); on `imemAck` latch `imemData`, →DECODE; else stay.
  - DECODE: `instrValid`=1; `stall`=1 stays and holds all outputs; `stall`=0 computes next fetch address, →FETCH.
- Next address on leaving DECODE, priority order:
  - `branchTaken` this cycle → `branchTarget`.
  - Pending branch → latched target.
  - `j` (0x02) → {(pc+4)[31:28], instr[25:0], 2'b00}.
  - Otherwise pc+4; wraps modulo 2^32.
- `branchTaken` in any other cycle latches a pending target; a later branch overwrites it (latest wins). Pending is cleared when consumed.
- Decode, all registered on the DECODE entry edge:
  - R-type (op 0): `address1`=rd, `address2`=rs, `address3`=rt, `regWrite`=1 except funct 0x08 (jr) or rd=0.
  - addi 0x08, addiu 0x09, slti 0x0A, lw 0x23: `address1`=rt, `address2`=rs, `address3`=0, `regWrite`=(rt≠0), `immediate` sign-extended.
  - andi 0x0C, ori 0x0D: as above, `immediate` zero-extended.
  - lui 0x0F: `address1`=rt, `address2`=0, `immediate`={imm,16'h0}, `regWrite`=(rt≠0).
  - sw 0x2B, beq 0x04, bne 0x05: `address1`=0, `address2`=rs, `address3`=rt, `regWrite`=0, `immediate` sign-extended.
  - j 0x02: all addresses 0, `regWrite`=0, `immediate`=0.
  - Any other opcode: `illegal`=1, `regWrite`=0, addresses 0; fetch continues at pc+4.
- `imemAck` outside FETCH is ignored.

## Timing
- Reset values: `pc`=`imemAddr`=PC_RESET, all other outputs 0, state IDLE, pending cleared.
- First `imemReq` occurs in the 2nd cycle after reset deasserts.
- `imemAck` at edge N → `instrValid`, `pc` and decode outputs valid from N+1.
- With `stall`=0 at N+1, FETCH resumes at N+2 with the new `imemAddr`.
- Throughput with same-cycle ack is 2 cycles per instruction.
- `pc` and `imemAddr` change only on the FETCH→DECODE and DECODE→FETCH edges respectively, never while `imemReq`=1 is waiting.
- Reset mid-fetch: `imemReq` drops immediately (async); a late `imemAck` is ignored.

## Test plan
- Reset, ack every request, `imemData`=0x012A4020 (add t0,t1,t2) → `pc`=0, `address1`=8, `address2`=9, `address3`=10, `regWrite`=1; next `imemAddr`=4.
- `imemData`=0x2408FFFF (addiu t0,zero,-1) → `immediate`=0xFFFFFFFF, `address1`=8, `regWrite`=1. Then 0x3508FFFF (ori) → `immediate`=0x0000FFFF.
- Hold `stall`=1 for 3 cycles in DECODE → `imemReq`=0, all outputs stable. Release → fetch at pc+4.
- At pc=0x10, `imemData`=0x08000040 (j) → `regWrite`=0, next `imemAddr`=0x100. Same cycle `branchTaken`=1, target 0x203 → `imemAddr`=0x200.
- `branchTaken` in FETCH with target 0x80, then a second branch with target 0x90 before DECODE exits → next fetch 0x90; the following fetch is 0x94.
- `imemData`=0xFC000000 → `illegal`=1, `regWrite`=0. Assert reset while `imemReq`=1 → immediate return to reset values; `imemAck` the next cycle is ignored.
